uart_rx_frame_parser: RTL

- Sits directly downstream of the UART receiver top and drains its RX FIFO through the `rx_rd_en` / `rx_rd_data` / `rx_empty` interface.
- Parses bytes into framed commands with this layout: SYNC, LEN, LEN payload bytes, CHK.
- Buffers the payload internally, verifies the XOR checksum, and only then emits the payload on a ready/valid byte stream.
- Flags malformed frames (bad length, bad checksum, inter-byte timeout) with one-cycle error pulses.

---
 rtl/uart_rx_frame_parser.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
// Drains a UART RX FIFO and parses frames of the form SYNC, LEN, LEN payload
// bytes, CHK. CHK is the XOR of LEN and every payload byte. The payload is
// buffered and released on a ready/valid byte stream only after the checksum
// matches. Malformed frames raise one-cycle error pulses.
//
// Ports:
//   clk           - system clock
//   rst           - synchronous active-low reset
//   rx_rd_data    - FIFO read data, valid the cycle after rx_rd_en
//   rx_empty      - FIFO empty flag
//   rx_rd_en      - FIFO read strobe, one cycle per byte
//   out_data      - payload byte
//   out_valid     - out_data valid
//   out_last      - final payload byte of the frame
//   out_ready     - downstream accepts the byte on out_valid && out_ready
//   frame_len     - length of the frame being or last emitted
//   len_error     - pulse on LEN == 0 or LEN > MAX_LEN
//   chk_error     - pulse on checksum mismatch
//   timeout_error - pulse on inter-byte timeout inside a frame
module uart_rx_frame_parser #(
  parameter int unsigned      N_BIT     = 8,
  parameter int unsigned      MAX_LEN   = 16,
  parameter logic [N_BIT-1:0] SYNC_BYTE = N_BIT'(8'hA5),
  parameter int unsigned      TIMEOUT   = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BIT-1:0]             rx_rd_data,
  input  logic                         rx_empty,
  output logic                         rx_rd_en,
  output logic [N_BIT-1:0]             out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  output logic                         len_error,
  output logic                         chk_error,
  output logic                         timeout_error
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_EMIT    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rx_rd_en_q, rx_rd_en_d;
  logic             cap_q, cap_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [N_BIT-1:0] chk_q, chk_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [N_BIT-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [LW-1:0]    frame_len_q, frame_len_d;
  logic             len_err_q, len_err_d;
  logic             chk_err_q, chk_err_d;
  logic             tmo_err_q, tmo_err_d;

  logic [N_BIT-1:0] buf_q [MAX_LEN];
  logic             buf_we_c;
  logic [AW-1:0]    buf_wa_c;
  logic [LW-1:0]    nxt_idx_c;

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_c) begin
      buf_q[buf_wa_c] <= rx_rd_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_HUNT;
      rx_rd_en_q  <= 1'b0;
      cap_q       <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_len_q <= '0;
      len_err_q   <= 1'b0;
      chk_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_rd_en_q  <= rx_rd_en_d;
      cap_q       <= cap_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_len_q <= frame_len_d;
      len_err_q   <= len_err_d;
      chk_err_q   <= chk_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  // Next-state, datapath and fetch control.
  always_comb begin
    state_d     = state_q;
    rx_rd_en_d  = 1'b0;
    cap_d       = rx_rd_en_q;   // FIFO data is valid the cycle after the strobe
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    tmo_d       = tmo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    frame_len_d = frame_len_q;
    len_err_d   = 1'b0;
    chk_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    buf_we_c    = 1'b0;
    buf_wa_c    = idx_q[AW-1:0];
    nxt_idx_c   = idx_q + LW'(1);

    case (state_q)
      S_HUNT: begin
        tmo_d = '0;
        if (cap_q && (rx_rd_data == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN, S_PAYLOAD, S_CSUM: begin
        if (cap_q) begin
          tmo_d = '0;
          case (state_q)
            S_LEN: begin
              if ((rx_rd_data == '0) || (rx_rd_data > N_BIT'(MAX_LEN))) begin
                len_err_d = 1'b1;
                state_d   = S_HUNT;
              end else begin
                len_d   = LW'(rx_rd_data);
                chk_d   = rx_rd_data;
                idx_d   = '0;
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              buf_we_c = 1'b1;
              chk_d    = chk_q ^ rx_rd_data;
              idx_d    = nxt_idx_c;
              if (nxt_idx_c == len_q) begin
                state_d = S_CSUM;
              end
            end
            default: begin
              if (rx_rd_data == chk_q) begin
                frame_len_d = len_q;
                idx_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = buf_q[AW'(0)];
                out_last_d  = (len_q == LW'(1));
                state_d     = S_EMIT;
              end else begin
                chk_err_d = 1'b1;
                state_d   = S_HUNT;
              end
            end
          endcase
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Counter would reach TIMEOUT this cycle: abandon the partial frame.
          tmo_err_d = 1'b1;
          tmo_d     = '0;
          state_d   = S_HUNT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_EMIT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
            state_d     = S_HUNT;
          end else begin
            idx_d      = nxt_idx_c;
            out_data_d = buf_q[nxt_idx_c[AW-1:0]];
            out_last_d = ((nxt_idx_c + LW'(1)) == frame_len_q);
          end
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase

    // One read in flight at most, and none while a frame is being emitted;
    // looking at state_d keeps a read from starting on the edge into EMIT.
    rx_rd_en_d = !rx_empty && !rx_rd_en_q && (state_d != S_EMIT);
  end

  assign rx_rd_en      = rx_rd_en_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign frame_len     = frame_len_q;
  assign len_error     = len_err_q;
  assign chk_error     = chk_err_q;
  assign timeout_error = tmo_err_q;

endmodule
